ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares one single-port RAM between N_REQ requesters, e.g. the CPU data port and a screen/DMA scanner.
- The RAM has a combinational read, a synchronous write, and load/address/in/out ports.
- Arbitration is round-robin with a registered one-hot grant. The owner may burst consecutive accesses, and is pre-empted after MAX_BURST accesses if another requester is waiting.
- The arbiter drives the RAM ports directly and returns registered read data to the owner.

Parameters:
N_REQ, 2, number of requesters (≥2)
REG_W, 16, data width, equals RAM REG_W
ADD_W, 3, address width, equals RAM ADD_W
MAX_BURST, 4, max consecutive accesses per grant while others wait (≥1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester access request; held while access wanted
we  in  N_REQ  per-requester write enable (1=write, 0=read)
addr  in  N_REQ*ADD_W  flattened addresses; requester i at [i*ADD_W +: ADD_W]
wdata  in  N_REQ*REG_W  flattened write data; requester i at [i*REG_W +: REG_W]
gnt  out  N_REQ  registered one-hot grant; all-zero when idle
rvalid  out  N_REQ  one-cycle pulse: rdata holds requester i's read result
rdata  out  REG_W  registered read data, shared by all requesters
ram_in  out  REG_W  to RAM in
ram_load  out  1  to RAM load
ram_address  out  ADD_W  to RAM address
ram_out  in  REG_W  from RAM out (combinational read)

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high; while reset=1, all state is held at its reset values.
- Reset values:
  - state=IDLE, gnt=0, rvalid=0, rdata=0, burst_cnt=0.
  - last=N_REQ-1, so requester 0 wins first.
  - ram_load=0, ram_address=0, ram_in=0.
- States: IDLE, BUSY (owner = index encoded in gnt).
- Round-robin pick: first i with req[i]=1, scanning cyclically from last+1. An exclude mask removes the current owner when it is pre-empted.
- IDLE:
  - No RAM access.
  - If any req=1, go to BUSY: gnt=onehot(pick), burst_cnt=0.
  - Grant latency is 1 cycle after req rises.
- BUSY, access cycle (req[owner]=1):
  - ram_address=addr[owner], ram_in=wdata[owner], ram_load=we[owner]; all combinational from state and inputs.
  - If we[owner]=0: at the edge, rdata<=ram_out and rvalid[owner]<=1 for one cycle. Read-to-data latency is 1 cycle.
  - Writes: ram_load=1, no rvalid, rdata unchanged.
  - burst_cnt increments.
- BUSY, release:
  - Owner drops req: no access that cycle (ram_load=0). last<=owner. Re-pick among the remaining reqs: go to BUSY with the new owner, or to IDLE if none.
  - Pre-emption: access cycle with burst_cnt==MAX_BURST-1 and another req pending. The access completes, then last<=owner and the pick excludes the owner.
  - At burst limit with no other req pending: burst_cnt<=0 and the owner keeps the grant (no idle bubble).
- Drive rules:
  - Requesters must not change addr/wdata/we of the granted port expecting effect before gnt is seen.
  - req from non-owners is ignored for access.
- RAM outputs are 0/ram_load=0 whenever not in a BUSY access cycle, including during reset.
- Reset mid-burst: grant is dropped immediately; a pending rvalid is cleared; no write is issued while reset=1.
- Read-during-write: not possible, since there is a single access per cycle.

Decomposition:
- Package ram_arb_pkg: state_t enum {IDLE, BUSY}; helper function onehot-to-index.
- OWN_W=$clog2(N_REQ) and BCNT_W=$clog2(MAX_BURST+1) are localparams in the module.
- One sub-module rr_pick, combinational:
  - Inputs: req, exclude mask, last.
  - Outputs: valid, idx.
  - Behaviour: cyclic priority scan from last+1.

Test Plan:
- Reset then req=2'b01, we=0, addr0=3 with RAM[3]=16'h00AA → gnt=01 on cycle 1, rvalid[0] pulse on cycle 2, rdata=16'h00AA.
- Port 1 writes 16'h1234 to addr 5 (single cycle), then reads addr 5 → ram_load pulse with address 5, then rdata=16'h1234 with rvalid[1].
- Both req held continuously, MAX_BURST=4 → grant sequence 0×4, 1×4, 0×4…; ram_address follows the owner's addr every cycle with no bubbles.
- Port 0 alone holds req for 10 cycles → gnt stays 01 through the burst_cnt wrap; 10 consecutive accesses.
- Owner 0 drops req while req1=1 → next cycle gnt=10, ram_load=0 in the drop cycle.
- Assert reset mid-burst during a write → gnt=0, rvalid=0, ram_load=0 immediately (asynchronous); after release, requester 0 has first priority.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector (up to 32 requesters).
    // An all-zero vector maps to 0.
    function automatic int unsigned oh2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester (excluding masked ones) scanning cyclically from i_last+1.
// Latency: combinational.
// Backpressure: none; o_vld is low when no eligible requester exists.
// Ports: i_req / i_excl (per-requester request and exclusion), i_last (previous owner),
//        o_vld (an eligible requester exists), o_idx (winning index).
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int OWN_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_excl,
    input  logic [OWN_W-1:0] i_last,
    output logic             o_vld,
    output logic [OWN_W-1:0] o_idx
);

    logic [N_REQ-1:0] w_cand;
    assign w_cand = i_req & ~i_excl;

    // Scan the furthest position first so the nearest candidate after
    // i_last overwrites the others and wins.
    always_comb begin
        int j;
        o_vld = 1'b0;
        o_idx = '0;
        j     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(i_last) + k) % N_REQ;
            if (w_cand[j[OWN_W-1:0]]) begin
                o_vld = 1'b1;
                o_idx = j[OWN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM (comb read, sync write) among N_REQ requesters, round-robin with bursts.
// Latency: grant 1 cycle after req; read data/rvalid 1 cycle after the access cycle.
// Backpressure: a requester holds req until it sees gnt; owner is pre-empted after MAX_BURST accesses if others wait.
// Ports: clk/reset; req/we/addr/wdata per requester (flattened); gnt one-hot owner;
//        rvalid/rdata registered read return; ram_in/ram_load/ram_address/ram_out to the RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int REG_W     = 16,
    parameter int ADD_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*ADD_W-1:0] addr,
    input  logic [N_REQ*REG_W-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rvalid,
    output logic [REG_W-1:0]       rdata,
    output logic [REG_W-1:0]       ram_in,
    output logic                   ram_load,
    output logic [ADD_W-1:0]       ram_address,
    input  logic [REG_W-1:0]       ram_out
);

    localparam int OWN_W  = $clog2(N_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rvalid;
    logic [REG_W-1:0]   r_rdata;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [OWN_W-1:0]   r_last;

    logic [OWN_W-1:0]   w_owner;
    logic               w_busy;
    logic               w_access;
    logic               w_burst_end;
    logic [N_REQ-1:0]   w_pick_excl;
    logic [OWN_W-1:0]   w_pick_last;
    logic               w_pick_vld;
    logic [OWN_W-1:0]   w_pick_idx;
    logic [N_REQ-1:0]   w_pick_oh;

    assign w_owner     = OWN_W'(oh2idx(32'(r_gnt)));
    assign w_busy      = (r_state == BUSY);
    assign w_access    = w_busy && req[w_owner];
    assign w_burst_end = (r_bcnt == BCNT_LAST);

    // While busy the picker always looks for someone other than the owner,
    // starting after the owner. On a release the owner's req is already low,
    // and on pre-emption the owner must not win again, so one setting covers both.
    assign w_pick_excl = w_busy ? r_gnt   : '0;
    assign w_pick_last = w_busy ? w_owner : r_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_pick (
        .i_req  (req),
        .i_excl (w_pick_excl),
        .i_last (w_pick_last),
        .o_vld  (w_pick_vld),
        .o_idx  (w_pick_idx)
    );

    assign w_pick_oh = N_REQ'(1) << w_pick_idx;

    // RAM is driven straight from the owner's port during an access cycle, zero otherwise.
    // Async reset forces r_state to IDLE, so these drop to zero as soon as reset rises.
    assign ram_load    = w_access && we[w_owner];
    assign ram_address = w_access ? addr[w_owner*ADD_W +: ADD_W]   : '0;
    assign ram_in      = w_access ? wdata[w_owner*REG_W +: REG_W]  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_bcnt   <= '0;
            r_last   <= OWN_W'(N_REQ - 1);
        end else begin
            r_rvalid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= BUSY;
                        r_gnt   <= w_pick_oh;
                        r_bcnt  <= '0;
                    end
                end
                BUSY: begin
                    if (w_access) begin
                        if (!we[w_owner]) begin
                            r_rdata  <= ram_out;
                            r_rvalid <= r_gnt;
                        end
                        if (w_burst_end) begin
                            // Burst limit: hand over if anyone else waits,
                            // otherwise the owner simply starts a fresh burst.
                            r_bcnt <= '0;
                            if (w_pick_vld) begin
                                r_last <= w_owner;
                                r_gnt  <= w_pick_oh;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end else begin
                        // Owner released: no access this cycle, re-arbitrate.
                        r_last <= w_owner;
                        r_bcnt <= '0;
                        if (w_pick_vld) begin
                            r_gnt <= w_pick_oh;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule
